// File: rtl/i2c_target.sv
// i2c_target
// I2C target (slave) responder with one fixed 7-bit address.
// SCL and SDA are oversampled on clk. The block recognises START, repeated
// START and STOP. It ACKs its own address and every byte the controller
// writes. Written bytes go to user logic, and read bytes are fetched from user
// logic. SDA is open-drain only: the block either pulls it low or releases it.
// SCL is never driven, so there is no clock stretching.
//
// Parameters
//   ADDR         own 7-bit target address
//   SYNC_STAGES  synchroniser depth on scl_i/sda_i (>= 2)
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   scl_i     SCL pad input (asynchronous)
//   sda_i     SDA pad input (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   rx_data   last byte written by the controller
//   rx_valid  one-cycle strobe, rx_data updated
//   tx_data   byte returned on the next read, latched while tx_req = 1
//   tx_req    one-cycle strobe, tx_data is latched in this cycle
//   busy      1 from address match until STOP or return to IDLE

module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_RX        = 3'd3;
  localparam logic [2:0] ST_RX_ACK    = 3'd4;
  localparam logic [2:0] ST_TX        = 3'd5;
  localparam logic [2:0] ST_TX_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [2:0]             state;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   rw;
  logic [7:0]             byte_in;
  logic                   load_tx;

  // The synchronisers and edge registers reset to 1, which matches an idle
  // bus. Leaving reset while the bus is idle therefore creates no false edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // START and STOP need SCL to be high in both the current and previous
  // sample. An SDA edge that arrives together with an SCL edge is data.
  assign start_det = scl_s & scl_d & ~sda_s & sda_d;
  assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;

  assign byte_in = {shift[6:0], sda_s};

  // A read byte is fetched in two places. The first is on the SCL fall that
  // ends the address ACK of a read. The second is on the first SCL fall in TX
  // after the controller ACKs the previous byte (TX with bit_cnt == 0).
  // START and STOP cannot coincide with an SCL fall, so no extra masking is
  // needed here.
  assign load_tx = scl_fall &
                   (((state == ST_ADDR_ACK) & sda_oe & rw) |
                    ((state == ST_TX) & (bit_cnt == 4'd0)));

  assign tx_req = load_tx;

  // Protocol FSM. Bus events take priority over bit handling. SDA is
  // sampled only on SCL rises, and sda_oe changes only on SCL falls.
  // In both ACK states, the first fall pulls SDA low and the following
  // fall releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'd0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift <= byte_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (shift[6:0] == ADDR) begin
                  rw    <= sda_s;
                  busy  <= 1'b1;
                  state <= ST_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                sda_oe  <= ~tx_data[7];
                shift   <= {tx_data[6:0], 1'b0};
                bit_cnt <= 4'd1;
                state   <= ST_TX;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_RX;
              end
            end
          end

          ST_RX: begin
            if (scl_rise) begin
              shift <= byte_in;
              if (bit_cnt == 4'd7) begin
                rx_data  <= byte_in;
                rx_valid <= 1'b1;
                bit_cnt  <= 4'd0;
                state    <= ST_RX_ACK;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RX_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_RX;
              end
            end
          end

          // bit_cnt counts the bits already placed on SDA. A value of 0
          // means a fresh byte must be fetched from user logic.
          ST_TX: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= ~tx_data[7];
                shift   <= {tx_data[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_TX_ACK;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                bit_cnt <= 4'd0;
                state   <= ST_TX;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end

          ST_WAIT_STOP: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
